sodor_1stage_mem_arbiter: RTL and testbench

SODOR_1STAGE_MEM_ARBITER -- requirements
Module: sodor_1stage_mem_arbiter

---
 rtl/sodor_1stage_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_sodor_1stage_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sodor_1stage_mem_arbiter.sv
// Arbitrates the Sodor 1-stage core's fetch and data ports onto one memory port.
// It allows one transaction in flight and a single-entry instruction buffer.
module sodor_1stage_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_imem_req_valid,
  input  logic [ADDR_W-1:0] io_imem_req_addr,
  output logic              io_imem_req_ready,
  output logic              io_imem_resp_valid,
  output logic [DATA_W-1:0] io_imem_resp_data,
  input  logic              io_imem_resp_ready,
  input  logic              io_imem_flush,
  input  logic              io_dmem_req_valid,
  input  logic [ADDR_W-1:0] io_dmem_req_addr,
  input  logic              io_dmem_req_fcn,
  input  logic [DATA_W-1:0] io_dmem_req_wdata,
  output logic              io_dmem_req_ready,
  output logic              io_dmem_resp_valid,
  output logic [DATA_W-1:0] io_dmem_resp_data,
  output logic              io_mem_req_valid,
  output logic [ADDR_W-1:0] io_mem_req_addr,
  output logic              io_mem_req_fcn,
  output logic [DATA_W-1:0] io_mem_req_wdata,
  input  logic              io_mem_req_ready,
  input  logic              io_mem_resp_valid,
  input  logic [DATA_W-1:0] io_mem_resp_data,
  output logic              io_dmiss,
  output logic              io_err
);

  typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_IMEM, GNT_DMEM} grant_t;

  state_t            state;
  grant_t            grant;
  logic              buf_full;
  logic [DATA_W-1:0] buf_data;
  logic              kill;
  logic              err;
  logic              dmiss;
  logic              mem_fire;

  // Data side wins outright; fetch only when the buffer has room for the reply.
  always_comb begin
    grant = GNT_NONE;
    if (state == IDLE) begin
      if (io_dmem_req_valid)
        grant = GNT_DMEM;
      else if (io_imem_req_valid && !buf_full)
        grant = GNT_IMEM;
    end
  end

  always_comb begin
    io_mem_req_valid = (grant != GNT_NONE);
    io_mem_req_addr  = io_imem_req_addr;
    io_mem_req_fcn   = 1'b0;
    io_mem_req_wdata = '0;
    if (grant == GNT_DMEM) begin
      io_mem_req_addr  = io_dmem_req_addr;
      io_mem_req_fcn   = io_dmem_req_fcn;
      io_mem_req_wdata = io_dmem_req_wdata;
    end
  end

  assign mem_fire           = io_mem_req_valid & io_mem_req_ready;
  assign io_dmem_req_ready  = (grant == GNT_DMEM) & io_mem_req_ready;
  assign io_imem_req_ready  = (grant == GNT_IMEM) & io_mem_req_ready;
  assign io_dmem_resp_valid = (state == D_WAIT) & io_mem_resp_valid;
  assign io_dmem_resp_data  = io_mem_resp_data;
  assign io_imem_resp_valid = buf_full;
  assign io_imem_resp_data  = buf_data;
  assign io_dmiss           = dmiss;
  assign io_err             = err;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      buf_full <= 1'b0;
      buf_data <= '0;
      kill     <= 1'b0;
      err      <= 1'b0;
      dmiss    <= 1'b0;
    end else begin
      if (io_imem_resp_ready || io_imem_flush)
        buf_full <= 1'b0;
      case (state)
        IDLE: begin
          dmiss <= mem_fire && (grant == GNT_DMEM);
          if (mem_fire) begin
            state <= (grant == GNT_DMEM) ? D_WAIT : I_WAIT;
            kill  <= io_imem_flush && (grant == GNT_IMEM);
          end
          if (io_mem_resp_valid)
            err <= 1'b1;
        end
        I_WAIT: begin
          // A flush arriving with the response drops it directly; kill only covers later arrivals.
          if (io_mem_resp_valid) begin
            state <= IDLE;
            kill  <= 1'b0;
            if (!kill && !io_imem_flush) begin
              buf_data <= io_mem_resp_data;
              buf_full <= 1'b1;
            end
          end else if (io_imem_flush) begin
            kill <= 1'b1;
          end
        end
        D_WAIT: begin
          dmiss <= !io_mem_resp_valid;
          if (io_mem_resp_valid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sodor_1stage_mem_arbiter.sv
// Directed bench for sodor_1stage_mem_arbiter: the memory side is driven by hand
// and outputs are checked 2 time units after each rising edge.
module tb_sodor_1stage_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_imem_req_valid;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_req_ready;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic        io_imem_resp_ready;
  logic        io_imem_flush;
  logic        io_dmem_req_valid;
  logic [31:0] io_dmem_req_addr;
  logic        io_dmem_req_fcn;
  logic [31:0] io_dmem_req_wdata;
  logic        io_dmem_req_ready;
  logic        io_dmem_resp_valid;
  logic [31:0] io_dmem_resp_data;
  logic        io_mem_req_valid;
  logic [31:0] io_mem_req_addr;
  logic        io_mem_req_fcn;
  logic [31:0] io_mem_req_wdata;
  logic        io_mem_req_ready;
  logic        io_mem_resp_valid;
  logic [31:0] io_mem_resp_data;
  logic        io_dmiss;
  logic        io_err;

  int n_total = 0;
  int n_bad   = 0;

  sodor_1stage_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_imem_req_valid  (io_imem_req_valid),
    .io_imem_req_addr   (io_imem_req_addr),
    .io_imem_req_ready  (io_imem_req_ready),
    .io_imem_resp_valid (io_imem_resp_valid),
    .io_imem_resp_data  (io_imem_resp_data),
    .io_imem_resp_ready (io_imem_resp_ready),
    .io_imem_flush      (io_imem_flush),
    .io_dmem_req_valid  (io_dmem_req_valid),
    .io_dmem_req_addr   (io_dmem_req_addr),
    .io_dmem_req_fcn    (io_dmem_req_fcn),
    .io_dmem_req_wdata  (io_dmem_req_wdata),
    .io_dmem_req_ready  (io_dmem_req_ready),
    .io_dmem_resp_valid (io_dmem_resp_valid),
    .io_dmem_resp_data  (io_dmem_resp_data),
    .io_mem_req_valid   (io_mem_req_valid),
    .io_mem_req_addr    (io_mem_req_addr),
    .io_mem_req_fcn     (io_mem_req_fcn),
    .io_mem_req_wdata   (io_mem_req_wdata),
    .io_mem_req_ready   (io_mem_req_ready),
    .io_mem_resp_valid  (io_mem_resp_valid),
    .io_mem_resp_data   (io_mem_resp_data),
    .io_dmiss           (io_dmiss),
    .io_err             (io_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs change 1 unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    io_imem_req_valid = 1'b0; io_imem_req_addr = '0;
    io_imem_resp_ready = 1'b0; io_imem_flush = 1'b0;
    io_dmem_req_valid = 1'b0; io_dmem_req_addr = '0;
    io_dmem_req_fcn = 1'b0; io_dmem_req_wdata = '0;
    io_mem_req_ready = 1'b1; io_mem_resp_valid = 1'b0; io_mem_resp_data = '0;
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_imem_resp_valid", 32'(io_imem_resp_valid), 32'd0);
    chk("rst_dmem_resp_valid", 32'(io_dmem_resp_valid), 32'd0);
    chk("rst_mem_req_valid",   32'(io_mem_req_valid),   32'd0);
    chk("rst_dmiss",           32'(io_dmiss),           32'd0);
    chk("rst_err",             32'(io_err),             32'd0);
    chk("rst_buf_data",        io_imem_resp_data,       32'h0);

    // Fetch, latency 3: request cycle 0, response cycle 3, buffered from cycle 4.
    io_imem_req_valid = 1'b1; io_imem_req_addr = 32'h100;
    settle();
    chk("f_req_valid", 32'(io_mem_req_valid), 32'd1);
    chk("f_req_addr",  io_mem_req_addr,       32'h100);
    chk("f_req_fcn",   32'(io_mem_req_fcn),   32'd0);
    chk("f_imem_rdy",  32'(io_imem_req_ready), 32'd1);
    chk("f_dmem_rdy",  32'(io_dmem_req_ready), 32'd0);
    tick();
    io_imem_req_valid = 1'b0;
    settle();
    chk("f_c1_req_valid", 32'(io_mem_req_valid), 32'd0);
    tick();
    io_imem_req_valid = 1'b1; io_imem_req_addr = 32'h104;
    settle();
    chk("f_c2_req_valid", 32'(io_mem_req_valid), 32'd0);
    tick();
    io_mem_resp_valid = 1'b1; io_mem_resp_data = 32'h00000013;
    settle();
    chk("f_c3_resp_valid", 32'(io_imem_resp_valid), 32'd0);
    chk("f_c3_dmem_valid", 32'(io_dmem_resp_valid), 32'd0);
    tick();
    io_mem_resp_valid = 1'b0;
    settle();
    chk("f_c4_resp_valid", 32'(io_imem_resp_valid), 32'd1);
    chk("f_c4_resp_data",  io_imem_resp_data,       32'h13);
    chk("full_no_req",     32'(io_mem_req_valid),   32'd0);
    chk("full_imem_rdy",   32'(io_imem_req_ready),  32'd0);
    tick();
    settle();
    chk("f_c5_hold",       32'(io_imem_resp_valid), 32'd1);
    chk("full_still_none", 32'(io_mem_req_valid),   32'd0);
    io_imem_resp_ready = 1'b1;
    settle();
    chk("full_consume_cyc", 32'(io_mem_req_valid), 32'd0);
    tick();
    io_imem_resp_ready = 1'b0;
    settle();
    chk("f_consumed",     32'(io_imem_resp_valid), 32'd0);
    chk("full_then_req",  32'(io_mem_req_valid),   32'd1);
    chk("full_then_addr", io_mem_req_addr,         32'h104);
    tick();
    io_imem_req_valid = 1'b0;
    io_mem_resp_valid = 1'b1; io_mem_resp_data = 32'h17;
    tick();
    io_mem_resp_valid = 1'b0;
    settle();
    chk("f2_data", io_imem_resp_data, 32'h17);
    io_imem_resp_ready = 1'b1;
    tick();
    io_imem_resp_ready = 1'b0;

    // Collision: dmem store beats a fetch; fetch goes after the store response.
    io_imem_req_valid = 1'b1; io_imem_req_addr = 32'h300;
    io_dmem_req_valid = 1'b1; io_dmem_req_addr = 32'h200;
    io_dmem_req_fcn = 1'b1; io_dmem_req_wdata = 32'hDEADBEEF;
    settle();
    chk("col_fcn",      32'(io_mem_req_fcn),    32'd1);
    chk("col_addr",     io_mem_req_addr,        32'h200);
    chk("col_wdata",    io_mem_req_wdata,       32'hDEADBEEF);
    chk("col_dmem_rdy", 32'(io_dmem_req_ready), 32'd1);
    chk("col_imem_rdy", 32'(io_imem_req_ready), 32'd0);
    tick();
    io_dmem_req_valid = 1'b0; io_dmem_req_fcn = 1'b0;
    settle();
    chk("col_wait_req", 32'(io_mem_req_valid), 32'd0);
    chk("col_dmiss",    32'(io_dmiss),         32'd1);
    io_mem_resp_valid = 1'b1; io_mem_resp_data = 32'h0;
    settle();
    chk("col_store_resp", 32'(io_dmem_resp_valid), 32'd1);
    tick();
    io_mem_resp_valid = 1'b0;
    settle();
    chk("col_fetch_valid", 32'(io_mem_req_valid),  32'd1);
    chk("col_fetch_addr",  io_mem_req_addr,        32'h300);
    chk("col_fetch_rdy",   32'(io_imem_req_ready), 32'd1);
    chk("col_dmiss_off",   32'(io_dmiss),          32'd0);
    tick();
    io_imem_req_valid = 1'b0;
    io_mem_resp_valid = 1'b1; io_mem_resp_data = 32'h33;
    tick();
    io_mem_resp_valid = 1'b0;
    settle();
    chk("col_fetch_data", io_imem_resp_data, 32'h33);
    io_imem_resp_ready = 1'b1;
    tick();
    io_imem_resp_ready = 1'b0;

    // dmiss timing: load with 2-cycle latency.
    io_dmem_req_valid = 1'b1; io_dmem_req_addr = 32'h40;
    settle();
    chk("dm_c0_dmiss", 32'(io_dmiss), 32'd0);
    tick();
    io_dmem_req_valid = 1'b0;
    settle();
    chk("dm_c1_dmiss", 32'(io_dmiss),           32'd1);
    chk("dm_c1_rv",    32'(io_dmem_resp_valid), 32'd0);
    tick();
    io_mem_resp_valid = 1'b1; io_mem_resp_data = 32'h1234;
    io_imem_flush = 1'b1;
    settle();
    chk("dm_c2_dmiss", 32'(io_dmiss),           32'd1);
    chk("dm_c2_rv",    32'(io_dmem_resp_valid), 32'd1);
    chk("dm_c2_data",  io_dmem_resp_data,       32'h1234);
    tick();
    io_mem_resp_valid = 1'b0; io_imem_flush = 1'b0;
    settle();
    chk("dm_c3_dmiss", 32'(io_dmiss),           32'd0);
    chk("dm_c3_rv",    32'(io_dmem_resp_valid), 32'd0);
    chk("dm_no_err",   32'(io_err),             32'd0);

    // Flush during I_WAIT drops the response; next fetch gets its own data.
    io_imem_req_valid = 1'b1; io_imem_req_addr = 32'h500;
    tick();
    io_imem_req_valid = 1'b0; io_imem_flush = 1'b1;
    tick();
    io_imem_flush = 1'b0;
    io_mem_resp_valid = 1'b1; io_mem_resp_data = 32'hAAAA5555;
    settle();
    chk("fl_c2_valid", 32'(io_imem_resp_valid), 32'd0);
    tick();
    io_mem_resp_valid = 1'b0;
    io_imem_req_valid = 1'b1; io_imem_req_addr = 32'h504;
    settle();
    chk("fl_dropped",  32'(io_imem_resp_valid), 32'd0);
    chk("fl_idle_req", 32'(io_mem_req_valid),   32'd1);
    chk("fl_err",      32'(io_err),             32'd0);
    tick();
    io_imem_req_valid = 1'b0;
    io_mem_resp_valid = 1'b1; io_mem_resp_data = 32'h77;
    tick();
    io_mem_resp_valid = 1'b0;
    settle();
    chk("fl_next_valid", 32'(io_imem_resp_valid), 32'd1);
    chk("fl_next_data",  io_imem_resp_data,       32'h77);
    io_imem_flush = 1'b1;
    tick();
    io_imem_flush = 1'b0;
    settle();
    chk("fl_clears_buf", 32'(io_imem_resp_valid), 32'd0);

    // Stray response in IDLE sets a sticky error.
    io_mem_resp_valid = 1'b1; io_mem_resp_data = 32'h99;
    settle();
    chk("err_no_dresp", 32'(io_dmem_resp_valid), 32'd0);
    tick();
    io_mem_resp_valid = 1'b0;
    settle();
    chk("err_set",     32'(io_err),             32'd1);
    chk("err_no_ibuf", 32'(io_imem_resp_valid), 32'd0);
    tick(); tick();
    chk("err_sticky", 32'(io_err), 32'd1);

    // Reset while in D_WAIT abandons the load.
    io_dmem_req_valid = 1'b1; io_dmem_req_addr = 32'h80;
    tick();
    io_dmem_req_valid = 1'b0;
    settle();
    chk("mr_dmiss_before", 32'(io_dmiss), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("mr_dmiss",   32'(io_dmiss),           32'd0);
    chk("mr_err",     32'(io_err),             32'd0);
    chk("mr_dresp",   32'(io_dmem_resp_valid), 32'd0);
    chk("mr_req_off", 32'(io_mem_req_valid),   32'd0);
    io_dmem_req_valid = 1'b1;
    settle();
    chk("mr_idle_grant", 32'(io_mem_req_valid), 32'd1);
    io_dmem_req_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
